maxpool2x2_fw: RTL and testbench
================================

Name: maxpool2x2_fw

Overview:
Forward 2x2/stride-2 max-pooling stage that sits directly downstream of the convolution forward unit. It reads the convolution output tensor (FP32, CHW, word-addressed) from memory and writes the pooled tensor back to memory. It is started by `go` and reports `done`, using the same go/done and memory request/avail handshake style as the other FPU compute stages.

Parameters:
- ADDR_W, 32, width of memory word pointers and base addresses.
- DIM_W, 16, width of the C/H/W dimension inputs.

Ports:
- clk  in  1  clock.
- rst_l  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled in IDLE only.
- done  out  1  high while in DONE.
- dim_c, dim_h, dim_w  in  DIM_W each  input tensor channels, height, width; sampled on accepted go.
- in_base, out_base  in  ADDR_W each  base word pointers for the input and output tensors; sampled on accepted go.
- rd_en  out  1  read request.
- rd_ptr  out  ADDR_W  read word address.
- rd_avail  in  1  read complete; rd_data is valid in this cycle.
- rd_data  in  32  read word.
- wr_en  out  1  write request.
- wr_ptr  out  ADDR_W  write word address.
- wr_data  out  32  write word.
- wr_avail  in  1  write complete.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state goes to IDLE.
  - done, rd_en, wr_en are 0; rd_ptr, wr_ptr, wr_data are 0; internal counters and max register are cleared.
  - Any pending memory request is abandoned.
- Output geometry:
  - OH = floor(H/2), OW = floor(W/2).
  - An odd last row or column is dropped.
- Addressing (all sums modulo 2^ADDR_W):
  - Input element (c,y,x) is at in_base + c*H*W + y*W + x.
  - Output element (c,oy,ox) is at out_base + c*OH*OW + oy*OW + ox.
  - Compute addresses with incremental counters/accumulators; no multiplier is required.
- Iteration order: c outer, then oy, then ox. The window is read in the order (0,0), (0,1), (1,0), (1,1).
- States:
  - IDLE: go=1 latches dims and bases.
    - If C=0, OH=0 or OW=0, go to DONE with no memory traffic.
    - Otherwise go to RD_REQ.
  - RD_REQ: assert rd_en, drive rd_ptr, go to RD_WAIT.
  - RD_WAIT: hold rd_en and rd_ptr stable until rd_avail=1.
    - On that cycle, capture rd_data and fold it into the max register. The first element of each window loads the register directly.
    - Deassert rd_en in the next cycle.
    - If fewer than 4 elements have been read, go to RD_REQ (next element). After the 4th, go to WR_REQ.
    - rd_avail has an arbitrary latency of at least 1 cycle.
  - WR_REQ: assert wr_en, drive wr_ptr and wr_data = max, go to WR_WAIT.
  - WR_WAIT: hold wr_en, wr_ptr and wr_data until wr_avail=1, then deassert wr_en.
    - If this was the last output element, go to DONE.
    - Otherwise advance ox/oy/c and go to RD_REQ.
  - DONE: done=1; stay here while go=1; go to IDLE when go=0.
- rd_en and wr_en are never high in the same cycle. rd_avail/wr_avail arriving while not waiting are ignored. go while busy is ignored.
- Max function (IEEE-754 binary32):
  - If either operand is NaN (exp=FF, mantissa≠0), the result is the canonical NaN 32'h7FC00000, and it sticks for the rest of the window.
  - -0 and +0 compare equal; the earlier-read operand is kept.
  - Otherwise use the standard total order: for two negatives the larger magnitude is smaller. Infinities are handled by the same ordering.
  - Ties keep the earlier-read operand.
- Throughput: 4 reads plus 1 write per output element; minimum 10 cycles per output element at avail latency 1.

Test Plan:
- C=1,H=2,W=2, in=[1.0,3.0,-2.0,2.5] (32'h3F800000,40400000,C0000000,40200000), in_base=0x100, out_base=0x200, avail latency 1 -> a single write of 32'h40400000 to 0x200; done asserts; exactly 4 reads at 0x100–0x103 in window order.
- C=2,H=4,W=4, input value = linear index as float -> 8 writes at 0x200–0x207 with values 5,7,13,15,21,23,29,31.
- C=1,H=3,W=5 -> OH=1, OW=2; reads touch only rows 0–1 and columns 0–3; 2 writes.
- Window {-0, +0, -1.0, NaN 32'h7F800001} -> writes 32'h7FC00000. Window {-0,+0,-1.0,-2.0} -> writes 32'h80000000. Window {-5.0,-3.0,-inf,-4.0} -> writes -3.0.
- Zero cases: C=0, or H=1, or W=1 -> done within 1 cycle of go with no rd_en/wr_en. Hold go high -> done stays high; drop go -> IDLE.
- Random rd_avail/wr_avail latency 1–7 with ptr/data checked stable while waiting; assert rst_l=0 mid-RD_WAIT -> all outputs 0 immediately, IDLE; a subsequent go reruns correctly.

Source files
------------

// File: rtl/maxpool2x2_fw.sv
// 2x2 stride-2 FP32 max-pool forward stage over a CHW tensor in word memory.
// One read per cycle pair, one write per window; go/done start handshake.
module maxpool2x2_fw #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              go,
    output logic              done,
    input  logic [DIM_W-1:0]  dim_c,
    input  logic [DIM_W-1:0]  dim_h,
    input  logic [DIM_W-1:0]  dim_w,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_ptr,
    input  logic              rd_avail,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [31:0]       wr_data,
    input  logic              wr_avail
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [2:0]        state;
    logic [DIM_W-1:0]  c_lim, oh_lim, ow_lim;
    logic [DIM_W-1:0]  c_cnt, oy_cnt, ox_cnt;
    logic [1:0]        elem;
    logic [ADDR_W-1:0] w_r, row_ptr, win_ptr;
    logic              h_odd;
    logic [31:0]       max_r;

    function automatic logic is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    // b strictly greater than a; signed zeros are equal
    function automatic logic gt(input logic [31:0] b, input logic [31:0] a);
        logic r;
        if (b[30:0] == 31'd0 && a[30:0] == 31'd0)
            r = 1'b0;
        else if (b[31] != a[31])
            r = ~b[31];
        else if (!b[31])
            r = b[30:0] > a[30:0];
        else
            r = b[30:0] < a[30:0];
        return r;
    endfunction

    function automatic logic [31:0] fold(input logic first,
                                         input logic [31:0] m,
                                         input logic [31:0] d);
        logic [31:0] r;
        if (is_nan(d) || (!first && is_nan(m)))
            r = QNAN;
        else if (first)
            r = d;
        else
            r = gt(d, m) ? d : m;
        return r;
    endfunction

    logic [1:0]        elem_nx;
    logic [ADDR_W-1:0] nxt_rd, nxt_row, nxt_win, row_step;
    logic              last_ox, last_oy, last_c, last_out, zero_job;
    logic [31:0]       fold_val;

    always_comb begin
        elem_nx  = elem + 2'd1;
        nxt_rd   = win_ptr + (elem_nx[1] ? w_r : '0) + ADDR_W'(elem_nx[0]);
        last_ox  = ox_cnt == ow_lim - DIM_W'(1);
        last_oy  = oy_cnt == oh_lim - DIM_W'(1);
        last_c   = c_cnt == c_lim - DIM_W'(1);
        last_out = last_ox && last_oy && last_c;
        row_step = w_r << 1;
        // an odd trailing row is skipped when crossing into the next channel
        nxt_row  = row_ptr + row_step + ((last_oy && h_odd) ? w_r : '0);
        nxt_win  = last_ox ? nxt_row : win_ptr + ADDR_W'(2);
        fold_val = fold(elem == 2'd0, max_r, rd_data);
        zero_job = (dim_c == '0) || (dim_h < DIM_W'(2)) ||
                   (dim_w < DIM_W'(2));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_ptr  <= '0;
            wr_en   <= 1'b0;
            wr_ptr  <= '0;
            wr_data <= '0;
            c_lim   <= '0;
            oh_lim  <= '0;
            ow_lim  <= '0;
            c_cnt   <= '0;
            oy_cnt  <= '0;
            ox_cnt  <= '0;
            elem    <= '0;
            w_r     <= '0;
            row_ptr <= '0;
            win_ptr <= '0;
            h_odd   <= 1'b0;
            max_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        c_lim   <= dim_c;
                        oh_lim  <= dim_h >> 1;
                        ow_lim  <= dim_w >> 1;
                        w_r     <= ADDR_W'(dim_w);
                        h_odd   <= dim_h[0];
                        row_ptr <= in_base;
                        win_ptr <= in_base;
                        wr_ptr  <= out_base;
                        c_cnt   <= '0;
                        oy_cnt  <= '0;
                        ox_cnt  <= '0;
                        elem    <= '0;
                        if (zero_job) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_RD_REQ;
                            rd_en  <= 1'b1;
                            rd_ptr <= in_base;
                        end
                    end
                end
                S_RD_REQ: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (rd_avail) begin
                        max_r <= fold_val;
                        elem  <= elem_nx;
                        if (elem == 2'd3) begin
                            rd_en   <= 1'b0;
                            wr_en   <= 1'b1;
                            wr_data <= fold_val;
                            state   <= S_WR_REQ;
                        end else begin
                            rd_ptr <= nxt_rd;
                            state  <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (wr_avail) begin
                        wr_en <= 1'b0;
                        if (last_out) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            wr_ptr  <= wr_ptr + ADDR_W'(1);
                            win_ptr <= nxt_win;
                            rd_ptr  <= nxt_win;
                            rd_en   <= 1'b1;
                            state   <= S_RD_REQ;
                            if (last_ox) begin
                                row_ptr <= nxt_row;
                                ox_cnt  <= '0;
                                if (last_oy) begin
                                    oy_cnt <= '0;
                                    c_cnt  <= c_cnt + DIM_W'(1);
                                end else begin
                                    oy_cnt <= oy_cnt + DIM_W'(1);
                                end
                            end else begin
                                ox_cnt <= ox_cnt + DIM_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!go) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2x2_fw.sv
// Directed bench for maxpool2x2_fw: window table, geometry sequences,
// zero-size jobs, random memory latency and mid-read reset.
module tb_maxpool2x2_fw;

    logic        clk = 1'b0;
    logic        rst_l, go, done;
    logic [15:0] dim_c, dim_h, dim_w;
    logic [31:0] in_base, out_base;
    logic        rd_en, rd_avail, wr_en, wr_avail;
    logic [31:0] rd_ptr, rd_data, wr_ptr, wr_data;

    always #5 clk = ~clk;

    maxpool2x2_fw #(.ADDR_W(32), .DIM_W(16)) dut (
        .clk(clk), .rst_l(rst_l), .go(go), .done(done),
        .dim_c(dim_c), .dim_h(dim_h), .dim_w(dim_w),
        .in_base(in_base), .out_base(out_base),
        .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_avail(rd_avail),
        .rd_data(rd_data), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .wr_data(wr_data), .wr_avail(wr_avail)
    );

    typedef struct {
        logic [31:0] w0, w1, w2, w3, exp;
    } vec_t;

    logic [31:0] mem [0:1023];
    logic [31:0] rq_addr[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int checks = 0;
    int failures = 0;
    int lat_lo = 1;
    int lat_hi = 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] itof(input int n);
        logic [31:0] nn, m;
        int e;
        nn = n;
        e = 0;
        if (n == 0) return 32'h0;
        for (int b = 0; b < 31; b++)
            if (nn[b]) e = b;
        m = nn << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // read responder: latency counted from the first cycle rd_en is seen
    initial begin
        logic [31:0] a;
        int lat;
        bit ab;
        rd_avail = 1'b0;
        rd_data = '0;
        forever begin
            if (rd_en && rst_l) begin
                a = rd_ptr;
                rq_addr.push_back(a);
                lat = $urandom_range(lat_hi, lat_lo);
                ab = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    if (!rst_l) begin ab = 1'b1; break; end
                    chk("rd_hold_en", {31'd0, rd_en}, 32'd1);
                    chk("rd_hold_ptr", rd_ptr, a);
                end
                if (!ab) begin
                    rd_avail = 1'b1;
                    rd_data = mem[a[9:0]];
                    @(posedge clk); #1;
                    rd_avail = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin
        logic [31:0] a, d;
        int lat;
        bit ab;
        wr_avail = 1'b0;
        forever begin
            if (wr_en && rst_l) begin
                a = wr_ptr;
                d = wr_data;
                wq_addr.push_back(a);
                wq_data.push_back(d);
                lat = $urandom_range(lat_hi, lat_lo);
                ab = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    if (!rst_l) begin ab = 1'b1; break; end
                    chk("wr_hold_en", {31'd0, wr_en}, 32'd1);
                    chk("wr_hold_ptr", wr_ptr, a);
                    chk("wr_hold_data", wr_data, d);
                end
                if (!ab) begin
                    mem[a[9:0]] = d;
                    wr_avail = 1'b1;
                    @(posedge clk); #1;
                    wr_avail = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    always @(negedge clk)
        if (rst_l)
            chk("rd_wr_exclusive", {31'd0, rd_en & wr_en}, 32'd0);

    task automatic run_job(input int c, input int h, input int w,
                           output int n);
        rq_addr.delete();
        wq_addr.delete();
        wq_data.delete();
        dim_c = 16'(c);
        dim_h = 16'(h);
        dim_w = 16'(w);
        in_base = 32'h100;
        out_base = 32'h200;
        go = 1'b1;
        n = 0;
        while (!done && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        go = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", {31'd0, done}, 32'd0);
    endtask

    task automatic load_linear(input int cnt);
        for (int i = 0; i < cnt; i++) mem[10'h100 + 10'(i)] = itof(i);
    endtask

    initial begin
        vec_t tbl[11];
        logic [31:0] e2[8];
        logic [31:0] e3[8];
        logic [31:0] e4[4];
        int n;

        tbl[0]  = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h40200000, 32'h40400000};
        tbl[1]  = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'h7F800001, 32'h7FC00000};
        tbl[2]  = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000, 32'h80000000};
        tbl[3]  = '{32'hC0A00000, 32'hC0400000, 32'hFF800000, 32'hC0800000, 32'hC0400000};
        tbl[4]  = '{32'hFFC00001, 32'h3F800000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
        tbl[5]  = '{32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000};
        tbl[6]  = '{32'h3F800000, 32'h7F800000, 32'hBF800000, 32'h40000000, 32'h7F800000};
        tbl[7]  = '{32'hBF800000, 32'h3F800000, 32'hC0000000, 32'h00000000, 32'h3F800000};
        tbl[8]  = '{32'h00000001, 32'h00000000, 32'h80000001, 32'h00000000, 32'h00000001};
        tbl[9]  = '{32'hC0000000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0000000};
        tbl[10] = '{32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000};
        e2 = '{32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000,
               32'h41A80000, 32'h41B80000, 32'h41E80000, 32'h41F80000};
        e3 = '{32'h100, 32'h101, 32'h105, 32'h106,
               32'h102, 32'h103, 32'h107, 32'h108};
        e4 = '{32'h40A00000, 32'h40E00000, 32'h41880000, 32'h41980000};

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_l = 1'b0;
        go = 1'b0;
        dim_c = '0; dim_h = '0; dim_w = '0;
        in_base = '0; out_base = '0;
        #3;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_rd_ptr", rd_ptr, 32'd0);
        chk("rst_wr_ptr", wr_ptr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            mem[10'h100] = tbl[k].w0;
            mem[10'h101] = tbl[k].w1;
            mem[10'h102] = tbl[k].w2;
            mem[10'h103] = tbl[k].w3;
            run_job(1, 2, 2, n);
            chk($sformatf("win%0d_nwr", k), wq_addr.size(), 1);
            if (wq_addr.size() == 1) begin
                chk($sformatf("win%0d_addr", k), wq_addr[0], 32'h200);
                chk($sformatf("win%0d_data", k), wq_data[0], tbl[k].exp);
            end
            if (k == 0) begin
                chk("t1_nrd", rq_addr.size(), 4);
                for (int i = 0; i < 4 && i < rq_addr.size(); i++)
                    chk("t1_rd_addr", rq_addr[i], 32'h100 + 32'(i));
                chk("t1_cycles", n, 11);
            end
        end

        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin lat_lo = 1; lat_hi = 7; end
            load_linear(32);
            run_job(2, 4, 4, n);
            chk("t2_nrd", rq_addr.size(), 32);
            chk("t2_nwr", wq_addr.size(), 8);
            for (int i = 0; i < 8 && i < wq_addr.size(); i++) begin
                chk("t2_addr", wq_addr[i], 32'h200 + 32'(i));
                chk("t2_data", wq_data[i], e2[i]);
            end
            if (pass == 0) chk("t2_cycles", n, 81);
        end
        lat_lo = 1; lat_hi = 1;

        load_linear(15);
        run_job(1, 3, 5, n);
        chk("t3_nrd", rq_addr.size(), 8);
        for (int i = 0; i < 8 && i < rq_addr.size(); i++)
            chk("t3_rd_addr", rq_addr[i], e3[i]);
        chk("t3_nwr", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            chk("t3_d0", wq_data[0], 32'h40C00000);
            chk("t3_d1", wq_data[1], 32'h41000000);
            chk("t3_a1", wq_addr[1], 32'h201);
        end

        load_linear(24);
        run_job(2, 3, 4, n);
        chk("t4_nwr", wq_addr.size(), 4);
        for (int i = 0; i < 4 && i < wq_addr.size(); i++)
            chk("t4_data", wq_data[i], e4[i]);

        for (int z = 0; z < 3; z++) begin
            rq_addr.delete();
            wq_addr.delete();
            dim_c = (z == 0) ? 16'd0 : 16'd1;
            dim_h = (z == 1) ? 16'd1 : 16'd4;
            dim_w = (z == 2) ? 16'd1 : 16'd4;
            go = 1'b1;
            @(posedge clk); #1;
            chk("zero_done", {31'd0, done}, 32'd1);
            repeat (3) @(posedge clk);
            #1;
            chk("zero_hold", {31'd0, done}, 32'd1);
            chk("zero_traffic", rq_addr.size() + wq_addr.size(), 0);
            go = 1'b0;
            @(posedge clk); #1;
            chk("zero_idle", {31'd0, done}, 32'd0);
        end

        lat_lo = 6; lat_hi = 6;
        mem[10'h100] = tbl[0].w0;
        mem[10'h101] = tbl[0].w1;
        mem[10'h102] = tbl[0].w2;
        mem[10'h103] = tbl[0].w3;
        dim_c = 16'd1; dim_h = 16'd2; dim_w = 16'd2;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #1;
        chk("mid_rd_en", {31'd0, rd_en}, 32'd1);
        #1 rst_l = 1'b0;
        #1;
        chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("arst_rd_ptr", rd_ptr, 32'd0);
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_l = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, rd_en | wr_en | done}, 32'd0);
        lat_lo = 1; lat_hi = 1;
        run_job(1, 2, 2, n);
        chk("rerun_nwr", wq_addr.size(), 1);
        if (wq_addr.size() == 1)
            chk("rerun_data", wq_data[0], 32'h40400000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
